// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// The control bundle packs every enable/flush so one assignment sets a whole pattern.
package pipeline_hazard_controller_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } hz_state_e;

   localparam logic [4:0] REG_ZERO            = 5'd0;
   localparam int         DEFAULT_MD_LATENCY  = 4;
   localparam int         DEFAULT_MEM_TIMEOUT = 255;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_ALL_EN = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                        exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b0,
                                        idex_flush: 1'b0, exmem_flush: 1'b0};
   localparam hz_ctrl_t CTRL_FREEZE = '{default: 1'b0};
   // Mult/div holds IF..EX and lets the older instruction drain past a bubble in EX/MEM.
   localparam hz_ctrl_t CTRL_MD_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                          exmem_en: 1'b1, memwb_en: 1'b1, ifid_flush: 1'b0,
                                          idex_flush: 1'b0, exmem_flush: 1'b1};

   function automatic logic load_use_hazard(
      input logic       ex_mem_read,
      input logic [4:0] ex_rt,
      input logic [4:0] id_rs,
      input logic [4:0] id_rt,
      input logic       id_uses_rt
   );
      return ex_mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module hazard_saturating_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (inc_i && (count_q != '1))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch/jump,
// multi-cycle mult/div occupancy of EX and data-memory wait states.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int MD_LATENCY  = DEFAULT_MD_LATENCY,
   parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_md_start,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_enable,
   output logic             ifid_enable,
   output logic             idex_enable,
   output logic             exmem_enable,
   output logic             memwb_enable,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count,
   output logic             mem_timeout
);

   localparam int MDC_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
   localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [MDC_W-1:0] MD_LOAD  = MDC_W'(MD_LATENCY - 2);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

   hz_state_e        state_q, state_d;
   logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
   logic             timeout_q, timeout_d;
   logic [TMR_W-1:0] frz_tmr;
   hz_ctrl_t         ctrl, ctrl_out;
   logic             mem_freeze;
   logic             load_use;

   assign mem_freeze = mem_req & ~mem_ack;
   assign load_use   = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

   always_comb begin
      ctrl     = CTRL_ALL_EN;
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      if (mem_freeze) begin
         // Memory wait wins in every state; MD countdown keeps running underneath.
         ctrl = CTRL_FREEZE;
         if ((state_q == MD_WAIT) && (md_cnt_q != '0))
            md_cnt_d = md_cnt_q - 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (ex_md_start) begin
                  ctrl     = CTRL_MD_STALL;
                  state_d  = MD_WAIT;
                  md_cnt_d = MD_LOAD;
               end else if (ex_branch_taken) begin
                  ctrl.ifid_flush = 1'b1;
                  ctrl.idex_flush = 1'b1;
               end else if (load_use) begin
                  ctrl.pc_en      = 1'b0;
                  ctrl.ifid_en    = 1'b0;
                  ctrl.idex_flush = 1'b1;
               end else if (id_jump) begin
                  ctrl.ifid_flush = 1'b1;
               end
            end
            MD_WAIT: begin
               if (md_cnt_q != '0) begin
                  ctrl     = CTRL_MD_STALL;
                  md_cnt_d = md_cnt_q - 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RUN;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   // Reset forces the pipeline open so the register instances clear cleanly.
   assign ctrl_out = reset ? ctrl : CTRL_ALL_EN;

   assign pc_enable    = ctrl_out.pc_en;
   assign ifid_enable  = ctrl_out.ifid_en;
   assign idex_enable  = ctrl_out.idex_en;
   assign exmem_enable = ctrl_out.exmem_en;
   assign memwb_enable = ctrl_out.memwb_en;
   assign ifid_flush   = ctrl_out.ifid_flush;
   assign idex_flush   = ctrl_out.idex_flush;
   assign exmem_flush  = ctrl_out.exmem_flush;
   assign md_busy      = reset & (state_q == MD_WAIT);

   hazard_saturating_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (~pc_enable),
      .clr_i   (1'b0),
      .count_o (stall_count)
   );

   hazard_saturating_counter #(.W(TMR_W)) u_freeze_tmr (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (mem_freeze),
      .clr_i   (~mem_freeze),
      .count_o (frz_tmr)
   );

   // Flag rises on the edge where the timer would reach MEM_TIMEOUT.
   assign timeout_d = timeout_q | (mem_freeze & (frz_tmr >= TMR_LAST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         timeout_q <= 1'b0;
      else
         timeout_q <= timeout_d;
   end

   assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed plus randomized bench for pipeline_hazard_controller against a behavioural model.
module tb_pipeline_hazard_controller;

   localparam int MD_LATENCY  = 4;
   localparam int MEM_TIMEOUT = 3;
   localparam int CNT_W       = 6;
   localparam int SAT         = (1 << CNT_W) - 1;

   // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl}
   localparam logic [7:0] P_ALL = 8'b11111_000;
   localparam logic [7:0] P_FRZ = 8'b00000_000;
   localparam logic [7:0] P_MD  = 8'b00011_001;
   localparam logic [7:0] P_BR  = 8'b11111_110;
   localparam logic [7:0] P_LU  = 8'b00111_010;
   localparam logic [7:0] P_JMP = 8'b11111_100;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
   logic             id_uses_rt = 0, id_jump = 0, ex_mem_read = 0, ex_branch_taken = 0;
   logic             ex_md_start = 0, mem_req = 0, mem_ack = 0;
   logic             pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
   logic             ifid_flush, idex_flush, exmem_flush, md_busy, mem_timeout;
   logic [CNT_W-1:0] stall_count;

   int n_chk = 0;
   int n_err = 0;

   // behavioural model state
   bit m_wait  = 0;
   int m_left  = 0;
   int m_stall = 0;
   int m_frun  = 0;
   bit m_to    = 0;

   pipeline_hazard_controller #(
      .MD_LATENCY(MD_LATENCY), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start), .mem_req(mem_req),
      .mem_ack(mem_ack), .pc_enable(pc_enable), .ifid_enable(ifid_enable),
      .idex_enable(idex_enable), .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .md_busy(md_busy), .stall_count(stall_count), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] model_ctrl();
      bit fr, lu;
      fr = mem_req && !mem_ack;
      lu = ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      if (!reset)          return P_ALL;
      if (fr)              return P_FRZ;
      if (m_wait)          return (m_left > 0) ? P_MD : P_ALL;
      if (ex_md_start)     return P_MD;
      if (ex_branch_taken) return P_BR;
      if (lu)              return P_LU;
      if (id_jump)         return P_JMP;
      return P_ALL;
   endfunction

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         m_wait = 0; m_left = 0; m_stall = 0; m_frun = 0; m_to = 0;
      end
      chk("ctrl", {24'd0, pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
                   ifid_flush, idex_flush, exmem_flush}, {24'd0, model_ctrl()});
      chk("md_busy", {31'd0, md_busy}, {31'd0, reset && m_wait});
      chk("stall_count", {26'd0, stall_count}, m_stall);
      chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
   end

   // Advance the model on the rising edge (inputs change 1 time unit later).
   always @(posedge clk) begin
      if (reset) begin
         bit fr;
         logic [7:0] c;
         fr = mem_req && !mem_ack;
         c  = model_ctrl();
         if (!c[7] && m_stall < SAT) m_stall++;
         if (fr) begin
            m_frun++;
            if (m_frun >= MEM_TIMEOUT) m_to = 1;
         end else begin
            m_frun = 0;
         end
         if (m_wait) begin
            if (m_left > 0) m_left--;
            else if (!fr) m_wait = 0;
         end else if (!fr && ex_md_start) begin
            m_wait = 1;
            m_left = MD_LATENCY - 2;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 0; id_jump = 0;
      ex_mem_read = 0; ex_branch_taken = 0; ex_md_start = 0; mem_req = 0; mem_ack = 0;
   endtask

   initial begin
      #1 reset = 0;
      #1;
      chk("rst_pc_en", {31'd0, pc_enable}, 1);
      chk("rst_md_busy", {31'd0, md_busy}, 0);
      chk("rst_stall", {26'd0, stall_count}, 0);
      chk("rst_timeout", {31'd0, mem_timeout}, 0);
      step(); step();
      reset = 1;

      // load-use on rs
      step(); ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; #2;
      chk("lu_pc_en", {31'd0, pc_enable}, 0);
      chk("lu_ifid_en", {31'd0, ifid_enable}, 0);
      chk("lu_idex_flush", {31'd0, idex_flush}, 1);
      step(); clr_in(); #2;
      chk("lu_one_bubble", {31'd0, pc_enable}, 1);
      chk("lu_stall", {26'd0, stall_count}, 1);

      // $zero never hazards
      step(); ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; #2;
      chk("zero_pc_en", {31'd0, pc_enable}, 1);

      // branch beats jump
      step(); clr_in(); ex_branch_taken = 1; id_jump = 1; #2;
      chk("br_ifid_flush", {31'd0, ifid_flush}, 1);
      chk("br_idex_flush", {31'd0, idex_flush}, 1);
      chk("br_pc_en", {31'd0, pc_enable}, 1);
      step(); clr_in(); #2;
      chk("br_stall", {26'd0, stall_count}, 1);

      // mult/div occupancy
      step(); ex_md_start = 1; #2;
      chk("md0_pc_en", {31'd0, pc_enable}, 0);
      chk("md0_exmem_fl", {31'd0, exmem_flush}, 1);
      step(); clr_in(); #2;
      chk("md1_busy", {31'd0, md_busy}, 1);
      chk("md1_pc_en", {31'd0, pc_enable}, 0);
      step(); #2;
      chk("md2_pc_en", {31'd0, pc_enable}, 0);
      step(); #2;
      chk("md3_release", {31'd0, pc_enable}, 1);
      chk("md3_exmem_fl", {31'd0, exmem_flush}, 0);
      step(); #2;
      chk("md_done_busy", {31'd0, md_busy}, 0);
      chk("md_stall", {26'd0, stall_count}, 4);

      // freeze while in MD_WAIT, watchdog fires after 3rd frozen edge
      step(); ex_md_start = 1;
      step(); clr_in(); mem_req = 1;
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("frz_pc_en", {31'd0, pc_enable}, 0);
         chk("frz_exmem_fl", {31'd0, exmem_flush}, 0);
         chk("frz_timeout", {31'd0, mem_timeout}, (i >= 3) ? 1 : 0);
         step();
      end
      mem_ack = 1; #2;
      chk("frz_release", {31'd0, pc_enable}, 1);
      step(); clr_in(); #2;
      chk("frz_stall", {26'd0, stall_count}, 10);
      chk("to_sticky", {31'd0, mem_timeout}, 1);

      // asynchronous reset in MD_WAIT
      step(); ex_md_start = 1;
      step(); clr_in(); #2;
      chk("ar_busy_before", {31'd0, md_busy}, 1);
      reset = 0; #1;
      chk("ar_busy", {31'd0, md_busy}, 0);
      chk("ar_stall", {26'd0, stall_count}, 0);
      chk("ar_pc_en", {31'd0, pc_enable}, 1);
      chk("ar_timeout", {31'd0, mem_timeout}, 0);
      step(); reset = 1;
      step(); #2;
      chk("ar_run", {31'd0, md_busy}, 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step();
         reset           = ($urandom_range(0, 149) != 0);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         ex_rt           = 5'($urandom_range(0, 3));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_mem_read     = ($urandom_range(0, 9) < 4);
         id_jump         = ($urandom_range(0, 9) < 2);
         ex_branch_taken = ($urandom_range(0, 19) < 3);
         ex_md_start     = ($urandom_range(0, 9) == 0);
         mem_req         = ($urandom_range(0, 9) < 3);
         mem_ack         = 1'($urandom_range(0, 1));
      end
      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
